// File: rtl/switch_conf_pkg.sv
// Shared types and constants for the DySER switch configuration sequencer.
// Holds the sequencer state encoding and the switch_output conf word defaults.
package switch_conf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_WAIT_Q = 3'd2,
      ST_COMMIT = 3'd3,
      ST_ERROR  = 3'd4
   } conf_state_t;

   localparam int SW_CONF_W = 4;
   localparam logic [SW_CONF_W-1:0] SW_CONF_OFF = 4'b0000;

endpackage

// File: rtl/switch_conf_ctrl.sv
// Configuration sequencer for one DySER switch: shadow-loads conf words, commits when fabric is idle.
// Optional macro SWITCH_CONF_PARITY_EN enables per-word even-parity checking and the ERROR state.
module switch_conf_ctrl
   import switch_conf_pkg::*;
#(
   parameter int NUM_OUT = 8,
   parameter int CONF_W  = SW_CONF_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cfg_start,
   input  logic                      cfg_valid,
   input  logic [CONF_W-1:0]         cfg_data,
   input  logic                      cfg_parity,
   output logic                      cfg_ready,
   input  logic                      fabric_idle,
   output logic [NUM_OUT*CONF_W-1:0] conf_out,
   output logic                      conf_busy,
   output logic                      conf_done,
   output logic                      conf_err
);

   localparam int CNT_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_OUT - 1);
   localparam logic [CONF_W-1:0] OFF_WORD = CONF_W'(SW_CONF_OFF);

   conf_state_t state_reg, state_next;
   logic [CNT_W-1:0]          cnt_reg;
   logic [CONF_W-1:0]         shadow_reg [NUM_OUT];
   logic [NUM_OUT*CONF_W-1:0] shadow_flat;
   logic [NUM_OUT*CONF_W-1:0] conf_out_reg;
   logic                      conf_busy_reg, conf_done_reg;
   logic                      handshake, parity_bad, shadow_we, commit_en;
   logic                      busy_next, restart;

`ifdef SWITCH_CONF_PARITY_EN
   logic conf_err_reg;
   assign parity_bad = ^{cfg_data, cfg_parity};
   assign conf_err   = conf_err_reg;
`else
   logic unused_parity;
   assign unused_parity = cfg_parity;
   assign parity_bad    = 1'b0;
   assign conf_err      = 1'b0;
`endif

   assign handshake = cfg_valid & cfg_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (cfg_start) state_next = ST_LOAD;
         end
         ST_LOAD: begin
            if (cfg_start)                              state_next = ST_LOAD;
            else if (handshake && parity_bad)           state_next = ST_ERROR;
            else if (handshake && cnt_reg == LAST_SLOT) state_next = ST_WAIT_Q;
         end
         ST_WAIT_Q: begin
            if (cfg_start)        state_next = ST_LOAD;
            else if (fabric_idle) state_next = ST_COMMIT;
         end
         ST_COMMIT: state_next = ST_IDLE;
         ST_ERROR: begin
            if (cfg_start) state_next = ST_LOAD;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // A commit in flight cannot be restarted, so cfg_start only counts outside COMMIT.
   always_comb begin
      cfg_ready = (state_reg == ST_LOAD) && !cfg_start;
      restart   = cfg_start && (state_reg != ST_COMMIT);
      shadow_we = handshake && !parity_bad;
      commit_en = (state_reg == ST_COMMIT);
      busy_next = (state_next == ST_LOAD) || (state_next == ST_WAIT_Q) ||
                  (state_next == ST_COMMIT);
   end

   generate
      for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_flat
         assign shadow_flat[gi*CONF_W +: CONF_W] = shadow_reg[gi];
      end
   endgenerate

   // Shadow needs no reset: a commit is only reachable after every slot is rewritten.
   always_ff @(posedge clk) begin
      if (shadow_we) shadow_reg[cnt_reg] <= cfg_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg       <= '0;
         conf_out_reg  <= {NUM_OUT{OFF_WORD}};
         conf_busy_reg <= 1'b0;
         conf_done_reg <= 1'b0;
      end else begin
         if (restart) begin
            cnt_reg <= '0;
         end else if (shadow_we && cnt_reg != LAST_SLOT) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
         if (commit_en) conf_out_reg <= shadow_flat;
         conf_busy_reg <= busy_next;
         conf_done_reg <= commit_en;
      end
   end

`ifdef SWITCH_CONF_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conf_err_reg <= 1'b0;
      end else begin
         conf_err_reg <= (state_next == ST_ERROR);
      end
   end
`endif

   assign conf_out  = conf_out_reg;
   assign conf_busy = conf_busy_reg;
   assign conf_done = conf_done_reg;

endmodule

// File: tb/tb_switch_conf_ctrl.sv
// Randomized bench for switch_conf_ctrl: a transaction-level model predicts conf_out and commit timing.
// Parity checks are exercised when SWITCH_CONF_PARITY_EN is defined.
module tb_switch_conf_ctrl;

   localparam int NUM_OUT = 8;
   localparam int CONF_W  = 4;
   localparam int W       = NUM_OUT * CONF_W;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          cfg_start = 1'b0;
   logic          cfg_valid = 1'b0;
   logic [CONF_W-1:0] cfg_data = '0;
   logic          cfg_parity = 1'b0;
   logic          fabric_idle = 1'b0;
   logic          cfg_ready;
   logic [W-1:0]  conf_out;
   logic          conf_busy, conf_done, conf_err;

   int checks = 0;
   int failures = 0;
   logic [W-1:0]      exp_conf = '0;
   logic [CONF_W-1:0] word_plan [NUM_OUT];

   switch_conf_ctrl #(.NUM_OUT(NUM_OUT), .CONF_W(CONF_W)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
      .cfg_data(cfg_data), .cfg_parity(cfg_parity), .cfg_ready(cfg_ready),
      .fabric_idle(fabric_idle), .conf_out(conf_out), .conf_busy(conf_busy),
      .conf_done(conf_done), .conf_err(conf_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_conf_out"},  64'(conf_out),  64'd0);
      check_eq({tag, "_cfg_ready"}, 64'(cfg_ready), 64'd0);
      check_eq({tag, "_busy"},      64'(conf_busy), 64'd0);
      check_eq({tag, "_done"},      64'(conf_done), 64'd0);
      check_eq({tag, "_err"},       64'(conf_err),  64'd0);
   endtask

   task automatic fill_random_plan();
      for (int i = 0; i < NUM_OUT; i++) word_plan[i] = CONF_W'($urandom_range(0, 15));
   endtask

   // Sends n_words of word_plan; with a full load and do_commit, waits idle_delay
   // cycles with fabric busy, then checks the commit lands exactly two edges later.
   task automatic load_words(input int n_words, input int idle_delay,
                             input bit do_commit, input bit skip_start);
      logic [W-1:0] new_conf;
      new_conf = '0;
      if (idle_delay > 0) fabric_idle = 1'b0;
      else fabric_idle = 1'($urandom_range(0, 1));
      if (!skip_start) begin
         cfg_start = 1'b1;
         tick();
         cfg_start = 1'b0;
      end
      check_eq("busy_in_load", 64'(conf_busy), 64'd1);
      for (int i = 0; i < n_words; i++) begin
         int gap;
         gap = $urandom_range(0, 2);
         cfg_valid = 1'b0;
         repeat (gap) tick();
         cfg_valid  = 1'b1;
         cfg_data   = word_plan[i];
         cfg_parity = ^word_plan[i];
         #1;
         check_eq("ready_in_load", 64'(cfg_ready), 64'd1);
         tick();
         new_conf = new_conf | (W'(word_plan[i]) << (CONF_W * i));
      end
      cfg_valid = 1'b0;
      if (n_words < NUM_OUT || !do_commit) return;
      repeat (idle_delay) begin
         check_eq("hold_old_conf", 64'(conf_out), 64'(exp_conf));
         check_eq("busy_waitq", 64'(conf_busy), 64'd1);
         tick();
      end
      fabric_idle = 1'b1;
      check_eq("no_early_done", 64'(conf_done), 64'd0);
      tick();
      fabric_idle = 1'($urandom_range(0, 1));
      check_eq("pre_commit_conf", 64'(conf_out), 64'(exp_conf));
      check_eq("pre_commit_done", 64'(conf_done), 64'd0);
      tick();
      exp_conf = new_conf;
      check_eq("commit_conf", 64'(conf_out), 64'(exp_conf));
      check_eq("commit_done", 64'(conf_done), 64'd1);
      tick();
      check_eq("done_one_cycle", 64'(conf_done), 64'd0);
      check_eq("busy_after", 64'(conf_busy), 64'd0);
      check_eq("conf_stable", 64'(conf_out), 64'(exp_conf));
   endtask

   task automatic async_reset(input string tag);
      #2 rst_n = 1'b0;
      #1;
      exp_conf = '0;
      check_reset_outputs(tag);
      #2 rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #8;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      // directed 1..8 with fabric idle
      for (int i = 0; i < NUM_OUT; i++) word_plan[i] = CONF_W'(i + 1);
      load_words(NUM_OUT, 0, 1'b1, 1'b0);
      check_eq("directed_1to8", 64'(conf_out), 64'h87654321);

      // held commit while fabric busy
      fill_random_plan();
      load_words(NUM_OUT, 20, 1'b1, 1'b0);

      // abort after 3 words, then full load of 0xA
      fill_random_plan();
      load_words(3, 0, 1'b0, 1'b0);
      for (int i = 0; i < NUM_OUT; i++) word_plan[i] = 4'hA;
      load_words(NUM_OUT, 0, 1'b1, 1'b0);
      check_eq("restart_all_A", 64'(conf_out), 64'hAAAAAAAA);

      // IDLE ignores cfg_valid
      cfg_valid = 1'b1;
      cfg_data  = 4'h5;
      repeat (3) begin
         #1;
         check_eq("idle_ready", 64'(cfg_ready), 64'd0);
         tick();
         check_eq("idle_busy", 64'(conf_busy), 64'd0);
      end
      cfg_valid = 1'b0;
      check_eq("idle_conf_kept", 64'(conf_out), 64'(exp_conf));

      // start and valid collide in LOAD
      fill_random_plan();
      load_words(2, 0, 1'b0, 1'b0);
      cfg_start = 1'b1;
      cfg_valid = 1'b1;
      cfg_data  = 4'hF;
      cfg_parity = 1'b0;
      #1;
      check_eq("collide_ready", 64'(cfg_ready), 64'd0);
      tick();
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      fill_random_plan();
      load_words(NUM_OUT, 0, 1'b1, 1'b1);

      // async reset mid-LOAD
      fill_random_plan();
      load_words(3, 0, 1'b0, 1'b0);
      async_reset("rst_load");

      // async reset in WAIT_Q after a real commit
      fill_random_plan();
      load_words(NUM_OUT, 0, 1'b1, 1'b0);
      fill_random_plan();
      fabric_idle = 1'b0;
      load_words(NUM_OUT, 1, 1'b0, 1'b0);
      fabric_idle = 1'b0;
      tick();
      check_eq("waitq_busy", 64'(conf_busy), 64'd1);
      check_eq("waitq_conf_old", 64'(conf_out), 64'(exp_conf));
      async_reset("rst_waitq");

`ifdef SWITCH_CONF_PARITY_EN
      for (int i = 0; i < NUM_OUT; i++) word_plan[i] = CONF_W'(i + 3);
      load_words(NUM_OUT, 0, 1'b1, 1'b0);
      fill_random_plan();
      load_words(2, 0, 1'b0, 1'b0);
      cfg_valid  = 1'b1;
      cfg_data   = 4'b0001;
      cfg_parity = 1'b0;
      tick();
      cfg_valid = 1'b0;
      check_eq("par_err_set", 64'(conf_err), 64'd1);
      check_eq("par_not_busy", 64'(conf_busy), 64'd0);
      check_eq("par_conf_kept", 64'(conf_out), 64'(exp_conf));
      repeat (3) tick();
      check_eq("par_err_sticky", 64'(conf_err), 64'd1);
      check_eq("par_ready_low", 64'(cfg_ready), 64'd0);
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      check_eq("par_err_clear", 64'(conf_err), 64'd0);
      fill_random_plan();
      load_words(NUM_OUT, 0, 1'b1, 1'b1);
`else
      check_eq("err_tied_low", 64'(conf_err), 64'd0);
`endif

      // randomized loads with aborts and fabric stalls
      for (int it = 0; it < 12; it++) begin
         int n;
         fill_random_plan();
         n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, NUM_OUT - 1)) : NUM_OUT;
         load_words(n, int'($urandom_range(0, 6)), 1'b1, 1'b0);
         check_eq("rand_conf", 64'(conf_out), 64'(exp_conf));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/switch_conf_ctrl.md
# switch_conf_ctrl

Configuration sequencer for one DySER switch. It accepts a stream of 4-bit switch-output configuration words over a valid/ready handshake and assembles them in a shadow register. It waits until the fabric reports no tokens in flight, then atomically commits the full set to the `conf` inputs of the switch's `switch_output` instances. The active configuration never changes while data is flowing, and a partial or corrupt load never reaches the datapath.

## Interface
Parameters:
- `NUM_OUT`, default 8: number of switch outputs configured, one word each.
- `CONF_W`, default 4: conf word width; matches the `switch_output` `conf` port.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cfg_start`  in  1  begin a new load; restarts any load in progress.
- `cfg_valid`  in  1  `cfg_data` word offered.
- `cfg_data`  in  `CONF_W`  configuration word.
- `cfg_parity`  in  1  even-parity bit over `cfg_data`; used only with `SWITCH_CONF_PARITY_EN`.
- `cfg_ready`  out  1  word accepted when `cfg_valid & cfg_ready`.
- `fabric_idle`  in  1  high when no valid tokens are in flight through this switch.
- `conf_out`  out  `NUM_OUT*CONF_W`  active configuration; output i occupies bits [i*CONF_W +: CONF_W].
- `conf_busy`  out  1  high in LOAD, WAIT_Q and COMMIT.
- `conf_done`  out  1  one-cycle pulse when a new configuration becomes active.
- `conf_err`  out  1  sticky parity error flag.

## Operation
States: IDLE, LOAD, WAIT_Q, COMMIT, ERROR.
- IDLE:
  - `cfg_start` -> LOAD, word counter = 0.
  - `cfg_valid` is ignored.
- LOAD:
  - `cfg_ready = ~cfg_start`.
  - Each handshake writes `cfg_data` into shadow slot `cnt`, then increments `cnt`.
  - The handshake with `cnt == NUM_OUT-1` -> WAIT_Q.
- WAIT_Q:
  - `fabric_idle = 1` -> COMMIT.
  - Otherwise the block holds in WAIT_Q indefinitely.
- COMMIT:
  - On exit, `conf_out <= shadow` and `conf_done <= 1`.
  - Next state is IDLE.
- ERROR:
  - `conf_err = 1`; the block holds until `cfg_start`.
- Restart via `cfg_start`:
  - In LOAD, WAIT_Q or ERROR, `cfg_start` -> LOAD with `cnt = 0`.
  - The shadow contents are discarded.
  - `conf_err` clears.
  - A simultaneous `cfg_valid` word is not accepted.
- `cfg_start` in COMMIT is ignored, so the commit always completes.
- `conf_out` changes only on the COMMIT exit edge and on reset. It never holds a partial load.
- Counter width is `$clog2(NUM_OUT)`. There is no wrap: the counter clears on entering LOAD.
- Reset mid-load: all loaded words are lost, and `conf_out` returns to all-zero (every output turned off).

## Timing
- Reset values:
  - state IDLE; `cfg_ready` 0; `conf_out` all 0.
  - `conf_busy` 0; `conf_done` 0; `conf_err` 0; `cnt` 0.
- `cfg_ready` is combinational from state and `cfg_start`. All other outputs are registered.
- Minimum latency, with `fabric_idle` held high:
  - final handshake at edge E moves to WAIT_Q;
  - edge E+1 moves to COMMIT;
  - edge E+2 updates `conf_out` and raises `conf_done` for exactly one cycle.
- Back-to-back words are accepted every cycle in LOAD; there are no bubbles.
- `fabric_idle` is sampled only in WAIT_Q. Its deassertion during COMMIT has no effect.

## Configuration
`SWITCH_CONF_PARITY_EN`:
- Defined:
  - A LOAD handshake with `^{cfg_data, cfg_parity} == 1` goes to ERROR.
  - The word is not stored and `conf_err` sets at that edge.
  - `conf_out` is unchanged.
- Undefined:
  - `cfg_parity` is ignored and ERROR is unreachable.
  - `conf_err` is tied 0.

## Structure
- Shared package `switch_conf_pkg`:
  - state enum `conf_state_t`;
  - `SW_CONF_W = 4`;
  - `SW_CONF_OFF = 4'b0000`.
- Single module with no sub-module. The shadow register is an in-module array.
- `switch_output` instances are placed by the switch top and fed slices of `conf_out`.

## Test plan
- Reset, then load 8 words 1..8 with `fabric_idle = 1` -> `conf_out = 32'h87654321` two edges after the last handshake; `conf_done` is high for one cycle.
- Load 8 words with `fabric_idle = 0` for 20 cycles -> `conf_out` stays at its old value and `conf_busy = 1`. Raise `fabric_idle` -> commit 2 edges later.
- `cfg_start` after 3 words, then 8 new words `4'hA` -> `conf_out = 32'hAAAAAAAA`; no earlier word survives.
- With `SWITCH_CONF_PARITY_EN` defined, send word `4'b0001` with parity 0 at slot 2 -> `conf_err = 1`, state ERROR, `conf_out` unchanged. The next `cfg_start` clears `conf_err`.
- Assert `rst_n = 0` asynchronously mid-LOAD and in WAIT_Q -> all outputs return to their reset values immediately, without waiting for a clock edge.
- Drive `cfg_valid` and `cfg_start` together in LOAD -> `cfg_ready = 0` that cycle, the word is not stored, and `cnt = 0`.
